decode_stage: RTL

Instruction decode stage that produces the operand and control bundle consumed by the Execute stage. It contains the 32×32 register file and decodes opcode, funct and immediate fields. It registers ALUReadData1, ALUReadData2, immediate, funct, ALUOp, ALUSrc and the downstream memory/writeback controls into a single pipeline register. It sits between instruction fetch and Execute, and accepts the writeback port from the last stage.

---
 rtl/decode_stage.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
//==============================================================================
// Module      : decode_stage
// Description : MIPS instruction decode stage. Holds the 32-entry register
//               file (with writeback-to-read bypass), decodes opcode and
//               immediate fields, and registers the operand/control bundle
//               that feeds the Execute stage.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module decode_stage #(
  parameter  int DATA_W = 32,
  parameter  int REG_N  = 32,
  localparam int IDX_W  = $clog2(REG_N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inValid,
  input  logic [31:0]       instruction,
  input  logic              stall,
  input  logic              flush,
  input  logic              wbRegWrite,
  input  logic [IDX_W-1:0]  wbReg,
  input  logic [DATA_W-1:0] wbData,
  output logic              outValid,
  output logic [DATA_W-1:0] ALUReadData1,
  output logic [DATA_W-1:0] ALUReadData2,
  output logic [DATA_W-1:0] immediate,
  output logic [5:0]        funct,
  output logic [2:0]        ALUOp,
  output logic              ALUSrc,
  output logic [IDX_W-1:0]  destReg,
  output logic              RegWrite,
  output logic              MemRead,
  output logic              MemWrite,
  output logic              MemtoReg,
  output logic              Branch
);

  localparam logic [5:0] C_OP_RTYPE = 6'b000000;
  localparam logic [5:0] C_OP_LW    = 6'b100011;
  localparam logic [5:0] C_OP_SW    = 6'b101011;
  localparam logic [5:0] C_OP_BEQ   = 6'b000100;
  localparam logic [5:0] C_OP_ADDI  = 6'b001000;
  localparam logic [5:0] C_OP_ANDI  = 6'b001100;
  localparam logic [5:0] C_OP_ORI   = 6'b001101;
  localparam logic [5:0] C_OP_SLTI  = 6'b001010;

  // Everything Execute consumes travels as one pipeline word, so a bubble is
  // simply the all-zero value.
  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [5:0]        funct;
    logic [2:0]        alu_op;
    logic              alu_src;
    logic [IDX_W-1:0]  dest;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              branch;
  } bundle_t;

  logic [DATA_W-1:0] rf_q [REG_N];
  logic [DATA_W-1:0] rf_d [REG_N];
  bundle_t           pipe_q;
  bundle_t           pipe_d;

  logic [5:0]        w_opcode;
  logic [IDX_W-1:0]  w_rs;
  logic [IDX_W-1:0]  w_rt;
  logic [IDX_W-1:0]  w_rd;
  logic [15:0]       w_imm16;
  logic              w_wb_en;
  logic [DATA_W-1:0] w_rs_val;
  logic [DATA_W-1:0] w_rt_val;
  logic              w_supported;
  logic              w_zero_ext;
  bundle_t           w_dec;

  assign w_opcode = instruction[31:26];
  assign w_rs     = instruction[25:21];
  assign w_rt     = instruction[20:16];
  assign w_rd     = instruction[15:11];
  assign w_imm16  = instruction[15:0];

  // r0 is hardwired to zero, so writes aimed at it are dropped here and it is
  // also excluded from the bypass path.
  assign w_wb_en  = wbRegWrite && (wbReg != '0);

  // Operand read with same-cycle writeback bypass.
  assign w_rs_val = (w_rs == '0)                 ? '0     :
                    (w_wb_en && (wbReg == w_rs)) ? wbData : rf_q[w_rs];
  assign w_rt_val = (w_rt == '0)                 ? '0     :
                    (w_wb_en && (wbReg == w_rt)) ? wbData : rf_q[w_rt];

  // Register-file next state: writeback runs regardless of stall/flush.
  always_comb begin
    rf_d = rf_q;
    if (w_wb_en) begin
      rf_d[wbReg] = wbData;
    end
  end

  // Register-file storage, fully cleared by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_q <= '{default: '0};
    end else begin
      rf_q <= rf_d;
    end
  end

  // Opcode decode into the next bundle; unknown opcodes and idle slots
  // collapse to a bubble.
  always_comb begin
    w_dec       = '0;
    w_supported = 1'b1;
    w_zero_ext  = 1'b0;
    case (w_opcode)
      C_OP_RTYPE: begin
        w_dec.alu_op    = 3'b010;
        w_dec.reg_write = 1'b1;
        w_dec.dest      = w_rd;
      end
      C_OP_LW: begin
        w_dec.alu_op     = 3'b000;
        w_dec.alu_src    = 1'b1;
        w_dec.mem_read   = 1'b1;
        w_dec.mem_to_reg = 1'b1;
        w_dec.reg_write  = 1'b1;
        w_dec.dest       = w_rt;
      end
      C_OP_SW: begin
        w_dec.alu_op    = 3'b000;
        w_dec.alu_src   = 1'b1;
        w_dec.mem_write = 1'b1;
      end
      C_OP_BEQ: begin
        w_dec.alu_op = 3'b001;
        w_dec.branch = 1'b1;
      end
      C_OP_ADDI, C_OP_ANDI, C_OP_ORI, C_OP_SLTI: begin
        w_dec.alu_src   = 1'b1;
        w_dec.reg_write = 1'b1;
        w_dec.dest      = w_rt;
        case (w_opcode)
          C_OP_ANDI: begin w_dec.alu_op = 3'b011; w_zero_ext = 1'b1; end
          C_OP_ORI:  begin w_dec.alu_op = 3'b100; w_zero_ext = 1'b1; end
          C_OP_SLTI: w_dec.alu_op = 3'b101;
          default:   w_dec.alu_op = 3'b000;
        endcase
      end
      default: w_supported = 1'b0;
    endcase

    w_dec.valid = 1'b1;
    w_dec.rd1   = w_rs_val;
    w_dec.rd2   = w_rt_val;
    w_dec.funct = instruction[5:0];
    w_dec.imm   = w_zero_ext ? {{(DATA_W-16){1'b0}}, w_imm16}
                             : {{(DATA_W-16){w_imm16[15]}}, w_imm16};

    if (!(inValid && w_supported)) begin
      w_dec = '0;
    end
  end

  // Pipeline-register next state: flush beats stall, stall beats load.
  always_comb begin
    pipe_d = pipe_q;
    if (flush) begin
      pipe_d = '0;
    end else if (!stall) begin
      pipe_d = w_dec;
    end
  end

  // Pipeline register toward Execute, cleared immediately by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign outValid     = pipe_q.valid;
  assign ALUReadData1 = pipe_q.rd1;
  assign ALUReadData2 = pipe_q.rd2;
  assign immediate    = pipe_q.imm;
  assign funct        = pipe_q.funct;
  assign ALUOp        = pipe_q.alu_op;
  assign ALUSrc       = pipe_q.alu_src;
  assign destReg      = pipe_q.dest;
  assign RegWrite     = pipe_q.reg_write;
  assign MemRead      = pipe_q.mem_read;
  assign MemWrite     = pipe_q.mem_write;
  assign MemtoReg     = pipe_q.mem_to_reg;
  assign Branch       = pipe_q.branch;

endmodule

`default_nettype wire
